// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// valid/ready handshake that hands {pc, instr} pairs on to decode.
interface if_fetch_queue_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, out_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// RV32 instruction-fetch stage: PC ownership, redirect priority (trap > mret > branch),
// single-outstanding fetch to a 1-cycle imem, and a DEPTH-entry {pc, instr} queue to ID.
module if_fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_queue_if.master fq,
  input  logic             br_taken_ex,
  input  logic [WIDTH-1:0] br_target_ex,
  input  logic             trap_take,
  input  logic             trap_irq,
  input  logic [4:0]       trap_cause,
  input  logic             mret_take,
  input  logic [WIDTH-1:0] mepc,
  input  logic [WIDTH-1:0] mtvec,
  output logic             redirect
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH-1:0] fifo_pc_q    [DEPTH];
  logic [WIDTH-1:0] fifo_instr_q [DEPTH];

  logic [WIDTH-1:0] trap_base;
  logic [WIDTH-1:0] trap_target;
  logic [WIDTH-1:0] raw_target;
  logic [WIDTH-1:0] redirect_target;
  logic [CNT_W:0]   occupancy;
  logic             issue;
  logic             push;
  logic             pop;
  logic             out_valid;

  // Redirect target selection; vectored offset applies only to interrupts.
  always_comb begin
    trap_base   = {mtvec[WIDTH-1:2], 2'b00};
    trap_target = trap_base;
    if (mtvec[1:0] == 2'b01 && trap_irq) begin
      trap_target = trap_base + {{(WIDTH-7){1'b0}}, trap_cause, 2'b00};
    end

    if (trap_take) begin
      raw_target = trap_target;
    end else if (mret_take) begin
      raw_target = mepc;
    end else begin
      raw_target = br_target_ex;
    end

    redirect_target      = raw_target;
    redirect_target[1:0] = 2'b00;
  end

  // Counting the outstanding fetch guarantees a slot for every response.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign redirect  = !rst && (trap_take || mret_take || br_taken_ex);
  assign issue     = !rst && !redirect && (occupancy < DEPTH_OCC);
  assign out_valid = (count_q != '0);
  assign push      = inflight_q && !redirect;
  assign pop       = out_valid && fq.out_ready && !redirect;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (redirect) begin
      pc_d     = redirect_target;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + WIDTH'(4);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Queue storage carries no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fifo_instr_q[wr_ptr_q] <= fq.imem_rdata;
    end
  end

  assign fq.imem_req  = issue;
  assign fq.imem_addr = pc_q;
  assign fq.out_valid = out_valid;
  assign fq.out_pc    = fifo_pc_q[rd_ptr_q];
  assign fq.out_instr = fifo_instr_q[rd_ptr_q];

endmodule
